bw_mult_seq: RTL



---
 rtl/bw_mult_pkg.sv | 18 +
 rtl/bw_pp_row.sv | 21 ++
 rtl/bw_mult_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bw_mult_pkg.sv
// Shared state encodings and Baugh-Wooley correction constant for bw_mult_seq.
// Optional MAC mode is selected by defining BW_MULT_MAC_EN.
package bw_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Correction constant 2^(a_w-1) + 2^(b_w-1) + 2^(a_w+b_w-1); callers truncate to P_W.
  function automatic logic [63:0] bw_k(input int a_w, input int b_w);
    logic [63:0] k;
    k = (64'd1 << (a_w - 1)) + (64'd1 << (b_w - 1)) + (64'd1 << (a_w + b_w - 1));
    return k;
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One Baugh-Wooley partial-product row: a AND b_bit, with the signed-mode
// inversions applied to the MSB term (ordinary rows) or the other terms (last row).
module bw_pp_row #(
  parameter int A_W = 8
) (
  input  logic [A_W-1:0] a,
  input  logic           b_bit,
  input  logic           tc,
  input  logic           last_row,
  output logic [A_W-1:0] row
);

  for (genvar gi = 0; gi < A_W; gi++) begin : g_bit
    if (gi == A_W - 1) begin : g_msb
      assign row[gi] = (a[gi] & b_bit) ^ (tc & ~last_row);
    end else begin : g_lsb
      assign row[gi] = (a[gi] & b_bit) ^ (tc & last_row);
    end
  end

endmodule

// File: rtl/bw_mult_seq.sv
// Sequential Baugh-Wooley multiplier, one partial-product row per clock, valid/ready on both sides.
// Define BW_MULT_MAC_EN to add the acc input (p accumulates previous p + a*b).
module bw_mult_seq
  import bw_mult_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 8,
  localparam int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           tc,
`ifdef BW_MULT_MAC_EN
  input  logic           acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] p,
  output logic           busy
);

  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [P_W-1:0] K = P_W'(bw_k(A_W, B_W));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             tc_q, tc_d;

  logic [A_W-1:0]   row;
  logic [P_W-1:0]   row_shift;
  logic [P_W-1:0]   acc_sum;
  logic [P_W-1:0]   load_base;
  logic [P_W-1:0]   load_val;
  logic             last_row;

  assign last_row = (cnt_q == CNT_W'(B_W - 1));

  // b_q shifts right each RUN cycle, so the current multiplier bit is always b_q[0].
  bw_pp_row #(.A_W(A_W)) u_row (
    .a        (a_q),
    .b_bit    (b_q[0]),
    .tc       (tc_q),
    .last_row (last_row),
    .row      (row)
  );

  assign row_shift = {{B_W{1'b0}}, row} << cnt_q;
  assign acc_sum   = acc_q + row_shift;

`ifdef BW_MULT_MAC_EN
  assign load_base = acc ? p_q : '0;
`else
  assign load_base = '0;
`endif
  assign load_val  = load_base + (tc ? K : '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    p_d       = p_q;
    a_d       = a_q;
    b_d       = b_q;
    tc_d      = tc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          tc_d    = tc;
          cnt_d   = '0;
          acc_d   = load_val;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        acc_d = acc_sum;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_row) begin
          cnt_d   = '0;
          p_d     = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tc_q    <= tc_d;
    end
  end

  assign p = p_q;

endmodule
